// File: rtl/regfile_param.sv
// Parametrised register file: two combinational read ports, one synchronous
// write port, optional hardwired zero register, write-to-read bypass and a
// sequenced bulk-clear engine that zeroes one register per cycle.
module regfile_param #(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned ZERO_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rdAddrA,
    input  logic [ADDR_W-1:0] rdAddrB,
    output logic [WIDTH-1:0]  rdDataA,
    output logic [WIDTH-1:0]  rdDataB,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [WIDTH-1:0]  wrData,
    input  logic              write,
    input  logic              clear,
    output logic              busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LastAddr = '1;

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]  regs_q [DEPTH];

    logic idle;
    logic wr_en;
    logic clr_we;
    logic bypass_en;
    logic zero_wr;

    // State register and clear counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: a clear request starts the sweep, the last register ends it
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (clear) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == LastAddr) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode: busy flag and storage write strobes
    always_comb begin
        idle      = (state_q == StIdle);
        busy      = (state_q == StClear);
        zero_wr   = (ZERO_EN != 0) && (wrAddr == LastAddr);
        bypass_en = idle && write;
        wr_en     = idle && write && !zero_wr;
        clr_we    = busy;
    end

    // Storage: reset wipes everything, the clear sweep owns the write port while busy
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (clr_we) begin
            regs_q[cnt_q] <= '0;
        end else if (wr_en) begin
            regs_q[wrAddr] <= wrData;
        end
    end

    // Read port A: zero register, then bypass, then storage
    always_comb begin
        rdDataA = regs_q[rdAddrA];
        if ((ZERO_EN != 0) && (rdAddrA == LastAddr)) begin
            rdDataA = '0;
        end else if (bypass_en && (wrAddr == rdAddrA)) begin
            rdDataA = wrData;
        end
    end

    // Read port B: same priority as port A
    always_comb begin
        rdDataB = regs_q[rdAddrB];
        if ((ZERO_EN != 0) && (rdAddrB == LastAddr)) begin
            rdDataB = '0;
        end else if (bypass_en && (wrAddr == rdAddrB)) begin
            rdDataB = wrData;
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: three configurations driven by shared stimulus and
// checked against an array-based model of the register file behaviour.
module tb_regfile_param;

    logic        clk;
    logic        rst;
    logic [4:0]  ra, rb, wa;
    logic [63:0] wd;
    logic        we, clr;

    logic [63:0] rda0, rdb0, rda1, rdb1;
    logic [7:0]  rda2, rdb2;
    logic        busy0, busy1, busy2;

    int n_cmp = 0;
    int n_err = 0;

    // Configurations: 0 = 64x32 no zero reg, 1 = 64x32 zero reg, 2 = 8x4 zero reg
    localparam int AW [3] = '{5, 5, 2};
    localparam int ZE [3] = '{0, 1, 1};

    logic [63:0] m [3][32];
    bit          busy_m [3];
    int          cnt_m [3];

    regfile_param #(.WIDTH(64), .ADDR_W(5), .ZERO_EN(0)) u_dut0 (
        .clk(clk), .reset(rst), .rdAddrA(ra), .rdAddrB(rb), .rdDataA(rda0), .rdDataB(rdb0),
        .wrAddr(wa), .wrData(wd), .write(we), .clear(clr), .busy(busy0)
    );

    regfile_param #(.WIDTH(64), .ADDR_W(5), .ZERO_EN(1)) u_dut1 (
        .clk(clk), .reset(rst), .rdAddrA(ra), .rdAddrB(rb), .rdDataA(rda1), .rdDataB(rdb1),
        .wrAddr(wa), .wrData(wd), .write(we), .clear(clr), .busy(busy1)
    );

    regfile_param #(.WIDTH(8), .ADDR_W(2), .ZERO_EN(1)) u_dut2 (
        .clk(clk), .reset(rst), .rdAddrA(ra[1:0]), .rdAddrB(rb[1:0]), .rdDataA(rda2),
        .rdDataB(rdb2), .wrAddr(wa[1:0]), .wrData(wd[7:0]), .write(we), .clear(clr),
        .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] wmask(input int i);
        return (i == 2) ? 64'hFF : {64{1'b1}};
    endfunction

    // Expected read value for configuration i at address addr
    function automatic logic [63:0] exp_rd(input int i, input logic [4:0] addr);
        int d = 1 << AW[i];
        int a = int'(addr) % d;
        if (ZE[i] != 0 && a == d - 1) return 64'h0;
        if (!busy_m[i] && we && (int'(wa) % d) == a) return wd & wmask(i);
        return m[i][a];
    endfunction

    // Model the effect of one rising edge with the inputs currently applied
    function automatic void model_edge();
        for (int i = 0; i < 3; i++) begin
            int d = 1 << AW[i];
            if (rst) begin
                for (int j = 0; j < 32; j++) m[i][j] = 64'h0;
                busy_m[i] = 1'b0;
                cnt_m[i]  = 0;
            end else if (busy_m[i]) begin
                m[i][cnt_m[i]] = 64'h0;
                cnt_m[i]++;
                if (cnt_m[i] == d) busy_m[i] = 1'b0;
            end else begin
                int a = int'(wa) % d;
                if (we && !(ZE[i] != 0 && a == d - 1)) m[i][a] = wd & wmask(i);
                if (clr) begin
                    busy_m[i] = 1'b1;
                    cnt_m[i]  = 0;
                end
            end
        end
    endfunction

    task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk(input string tag);
        cmp({tag, " dut0.A"}, rda0, exp_rd(0, ra));
        cmp({tag, " dut0.B"}, rdb0, exp_rd(0, rb));
        cmp({tag, " dut0.busy"}, {63'b0, busy0}, {63'b0, busy_m[0]});
        cmp({tag, " dut1.A"}, rda1, exp_rd(1, ra));
        cmp({tag, " dut1.B"}, rdb1, exp_rd(1, rb));
        cmp({tag, " dut1.busy"}, {63'b0, busy1}, {63'b0, busy_m[1]});
        cmp({tag, " dut2.A"}, {56'b0, rda2}, exp_rd(2, ra));
        cmp({tag, " dut2.B"}, {56'b0, rdb2}, exp_rd(2, rb));
        cmp({tag, " dut2.busy"}, {63'b0, busy2}, {63'b0, busy_m[2]});
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int k;
        int b2;
        for (int i = 0; i < 3; i++) begin
            busy_m[i] = 1'b0;
            cnt_m[i]  = 0;
            for (int j = 0; j < 32; j++) m[i][j] = 64'h0;
        end
        rst = 1'b1; we = 1'b0; clr = 1'b0; wa = '0; wd = '0; ra = '0; rb = '0;
        @(negedge clk);
        cycle();
        rst = 1'b0;

        // Every address reads zero after reset
        for (int i = 0; i < 32; i++) begin
            ra = 5'(i); rb = 5'(31 - i);
            #1 chk("reset");
        end

        // Fill with random data, checking the bypass on the way
        for (int i = 0; i < 32; i++) begin
            we = 1'b1; wa = 5'(i); wd = {$urandom, $urandom};
            ra = 5'(i); rb = 5'(i - 1);
            #1 chk("fill_bypass");
            cycle();
        end
        we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ra = 5'(i); rb = 5'(i - 1);
            #1 chk("readback");
        end

        // Zero register: with the write active, then after it
        we = 1'b1; wa = 5'd31; wd = 64'hDEAD_BEEF_0123_4567; ra = 5'd31; rb = 5'd31;
        #1 chk("zero_wr_active");
        cmp("zero_reg dut1 direct", rda1, 64'h0);
        cycle();
        we = 1'b0;
        #1 chk("zero_after");
        cmp("reg31 dut0 holds", rda0, 64'hDEAD_BEEF_0123_4567);

        // Bypass directed cases
        we = 1'b1; wa = 5'd7; wd = 64'h1111; ra = 5'd7; rb = 5'd7;
        #1 chk("bypass_both");
        cmp("bypass dut0 direct", rdb0, 64'h1111);
        we = 1'b0;
        #1 chk("bypass_off");
        we = 1'b1; wa = 5'd8; wd = {$urandom, $urandom}; ra = 5'd7; rb = 5'd8;
        #1 chk("bypass_split");
        cycle();
        we = 1'b0;

        // Clear sequence over a file of nonzero data
        for (int i = 0; i < 32; i++) begin
            we = 1'b1; wa = 5'(i); wd = {$urandom, $urandom} | 64'h1;
            cycle();
        end
        we = 1'b0; clr = 1'b1;
        #1 chk("clear_req");
        cycle();
        clr = 1'b0;
        k = 0; b2 = 0;
        while (busy0 && k < 100) begin
            if (busy2) b2++;
            we = (k == 10); wa = 5'd3; wd = 64'h55;
            ra = 5'(k - 1); rb = 5'(k);
            #1 chk("clear_run");
            cycle();
            k++;
        end
        cmp("clear busy cycles dut0", 64'(k), 64'd32);
        cmp("clear busy cycles dut2", 64'(b2), 64'd4);
        we = 1'b1; wa = 5'd5; wd = 64'hCAFE; ra = 5'd3; rb = 5'd5;
        #1 chk("post_clear_wr");
        cmp("dropped write dut0", rda0, 64'h0);
        cycle();
        we = 1'b0;
        #1 chk("post_clear_land");
        cmp("landed write dut0", rdb0, 64'hCAFE);

        // Reset in the middle of a clear sweep
        for (int i = 0; i < 32; i++) begin
            we = 1'b1; wa = 5'(i); wd = {$urandom, $urandom} | 64'h2;
            cycle();
        end
        we = 1'b0; clr = 1'b1;
        cycle();
        clr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ra = 5'(i); rb = 5'(i + 5);
            #1 chk("midclear");
            cycle();
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cmp("midclear reset busy0", {63'b0, busy0}, 64'h0);
        for (int i = 0; i < 32; i++) begin
            ra = 5'(i); rb = 5'(31 - i);
            #1 chk("midclear_zero");
        end
        we = 1'b1; wa = 5'd20; wd = 64'hA5; ra = 5'd20;
        cycle();
        we = 1'b0;
        #1 chk("midclear_wr");
        cmp("midclear write dut0", rda0, 64'hA5);

        // Small config: 8-bit write to reg[2]
        we = 1'b1; wa = 5'd2; wd = 64'hFF;
        cycle();
        we = 1'b0; ra = 5'd2; rb = 5'd3;
        #1 chk("small_rw");
        cmp("small reg2", {56'b0, rda2}, 64'hFF);

        // Random traffic including occasional clears and resets
        for (int n = 0; n < 400; n++) begin
            we  = 1'($urandom);
            wa  = 5'($urandom); ra = 5'($urandom); rb = 5'($urandom);
            if ($urandom_range(0, 3) == 0) rb = wa;
            wd  = {$urandom, $urandom};
            clr = ($urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 149) == 0);
            #1 chk("random");
            cycle();
        end
        rst = 1'b0; clr = 1'b0; we = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised general-purpose register file for the datapath, the successor to the fixed 32x64 file. It keeps two asynchronous read ports and one synchronous write port, and adds four things:
- configurable width and depth;
- an optional hardwired zero register (LEGv8 XZR);
- write-to-read bypass;
- a sequenced bulk-clear engine that zeroes the file one register per cycle while signalling busy.

## Interface
Parameters:
- WIDTH, 64, data width in bits (>= 1)
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- ZERO_EN, 1, 1 = register DEPTH-1 reads as zero and ignores writes; 0 = ordinary register

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high
- rdAddrA  in  ADDR_W  read address, port A
- rdAddrB  in  ADDR_W  read address, port B
- rdDataA  out  WIDTH  read data, port A (combinational)
- rdDataB  out  WIDTH  read data, port B (combinational)
- wrAddr  in  ADDR_W  write address
- wrData  in  WIDTH  write data
- write  in  1  write enable
- clear  in  1  bulk-clear request (level, sampled each edge)
- busy  out  1  high while the clear engine runs

## Operation
Storage is DEPTH x WIDTH flops. There are no extra state bits beyond the FSM and the clear counter.

FSM states and transitions:
- IDLE: external writes accepted. On an edge with clear=1 and write=0 or 1, go to CLEAR and set cnt=0. Any write presented on that same edge is still performed.
- CLEAR: each edge writes zero to reg[cnt] and increments cnt. The edge that writes reg[DEPTH-1] returns the FSM to IDLE.
- In CLEAR, write is ignored (dropped, not queued). clear is ignored; there is no restart.

Write rule (IDLE only):
- On the edge, if write=1, reg[wrAddr] <= wrData.
- When ZERO_EN=1 and wrAddr=DEPTH-1, the write is discarded.

Read rule, evaluated per port in this priority order:
1. If ZERO_EN=1 and rdAddr=DEPTH-1, output 0.
2. Else if FSM=IDLE, write=1 and wrAddr=rdAddr, output wrData (bypass).
3. Else output reg[rdAddr].

Both ports may read the same address, and may hit the bypass simultaneously.

Reads during CLEAR return current storage contents:
- already-cleared registers read 0;
- uncleared registers read their old value.

busy = (FSM==CLEAR).

Reset:
- Synchronous. On an edge with reset=1, all registers become 0, FSM=IDLE, cnt=0, busy=0.
- reset overrides write and clear on the same edge.
- Reset mid-CLEAR aborts the sequence; everything reads 0 afterwards anyway.

## Timing
- Read latency: 0 cycles. Outputs are combinational from addresses, storage and the bypass path.
- Write latency: the value is visible via bypass in the same cycle, and from storage after the edge.
- Clear: the request edge is E0. Edges E1..E(DEPTH) zero reg[0]..reg[DEPTH-1].
  - busy is high from just after E0 until just after E(DEPTH), i.e. DEPTH cycles.
  - The first accepted write is on edge E(DEPTH+1).
- A clear held high continuously restarts a new sequence on the first edge after busy falls. Sources pulse clear for one cycle.
- Reset values: rdDataA/B = 0 for every address after reset, busy = 0.

## Test plan
- Reset and fill, WIDTH=64, ADDR_W=5, ZERO_EN=0:
  - reset one cycle, then check every address reads 0;
  - write reg[i] = {$random,$random} for i=0..31, then read A=i, B=i-1 and compare against the model;
  - reg[31] holds its written value.
- Zero register, ZERO_EN=1: write 64'hDEAD_BEEF_0123_4567 to address 31, then A=31 and B=31 read 0, with and without the write active in the same cycle.
- Bypass:
  - write=1, wrAddr=7, wrData=64'h1111; A=7, B=7 both read 64'h1111 before the edge;
  - with write=0 the old reg[7] is shown;
  - A=7, B=8 with a write to 8 gives A=old reg[7], B=wrData.
- Clear sequence, ADDR_W=5:
  - fill all registers with nonzero data, pulse clear one cycle;
  - busy is high for exactly 32 cycles;
  - at cycle k of CLEAR, reg[0..k-1]=0 and reg[k..31] hold old data;
  - a write to reg[3]=64'h55 during busy is dropped (reads 0 after);
  - the write on the first cycle after busy falls lands.
- Reset mid-clear: pulse clear, reset at CLEAR cycle 10; the next cycle has busy=0 and all registers 0, and a write of 64'hA5 to reg[20] is accepted immediately.
- Small config, WIDTH=8, ADDR_W=2, ZERO_EN=1: four registers, reg[3] reads 0; clear takes 4 busy cycles; an 8-bit write of 8'hFF to reg[2] reads back 8'hFF.
